// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned ADDR_W_MAX = 32;
  localparam int unsigned DATA_W_MAX = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_DONE  = 3'd4
  } state_e;

  // Command captured from the winning requester at grant time
  typedef struct packed {
    logic                  wr;
    logic [ADDR_W_MAX-1:0] addr;
    logic [DATA_W_MAX-1:0] wdata;
    logic                  id;
  } cmd_t;

  // Requester index to one-hot vector
  function automatic logic [NUM_REQ-1:0] id2oh(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker with optional hold-on-last override.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  input  logic               hold_i,
  output logic [NUM_REQ-1:0] win_c_o
);

  // Hold keeps the last winner; a tie goes to the side not granted last
  always_comb begin
    win_c_o = '0;
    if (hold_i && req_i[last_i]) begin
      win_c_o = id2oh(last_i);
    end else if (req_i == 2'b11) begin
      win_c_o = id2oh(~last_i);
    end else begin
      win_c_o = req_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory with pulsed write strobe.
// Optional feature: define DMEM_ARB_LOCK_EN to add the lock input and LOCK_MAX.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
`ifdef DMEM_ARB_LOCK_EN
  ,
  parameter int unsigned LOCK_MAX = 8
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] wr,
  input  logic [AW-1:0]      addr0,
  input  logic [AW-1:0]      addr1,
  input  logic [DW-1:0]      wdata0,
  input  logic [DW-1:0]      wdata1,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0] lock,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      mem_raddr,
  output logic [AW-1:0]      mem_waddr,
  output logic               mem_we,
  output logic [DW-1:0]      mem_din,
  input  logic [DW-1:0]      mem_dout
);

  state_e              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic                last_q, last_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [AW-1:0]       mem_waddr_q, mem_waddr_d;
  logic [DW-1:0]       mem_din_q, mem_din_d;
  logic                mem_we_q, mem_we_d;

  logic [NUM_REQ-1:0]  win_c;
  logic                win_id_c;
  logic                hold_c;
  logic [AW-1:0]       win_addr_c;
  logic [DW-1:0]       win_wdata_c;
  logic                unused_cmd;

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned LCW = $clog2(LOCK_MAX + 1);
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           lock_act_q, lock_act_d;

  // Last winner keeps the memory while it was locked and has budget left
  assign hold_c = lock_act_q && (lock_cnt_q < LCW'(LOCK_MAX));
`else
  assign hold_c = 1'b0;
`endif

  rr_pick2 u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .hold_i  (hold_c),
    .win_c_o (win_c)
  );

  assign win_id_c    = win_c[1];
  assign win_addr_c  = win_id_c ? addr1 : addr0;
  assign win_wdata_c = win_id_c ? wdata1 : wdata0;

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_raddr = cmd_q.addr[AW-1:0];
  assign mem_waddr = mem_waddr_q;
  assign mem_din   = mem_din_q;
  assign mem_we    = mem_we_q;

  // Latched command fields not driven to a port are kept for debug visibility
  assign unused_cmd = ^cmd_q;

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    last_d      = last_q;
    gnt_d       = '0;
    done_d      = '0;
    rdata_d     = rdata_q;
    mem_waddr_d = mem_waddr_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    lock_cnt_d  = lock_cnt_q;
    lock_act_d  = lock_act_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          cmd_d.wr    = wr[win_id_c];
          cmd_d.id    = win_id_c;
          cmd_d.addr  = ADDR_W_MAX'(win_addr_c);
          cmd_d.wdata = DATA_W_MAX'(win_wdata_c);
          last_d      = win_id_c;
          gnt_d       = win_c;
`ifdef DMEM_ARB_LOCK_EN
          lock_act_d  = lock[win_id_c];
          if (win_id_c != last_q) begin
            lock_cnt_d = LCW'(1);
          end else if (lock_cnt_q < LCW'(LOCK_MAX)) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end
`endif
          if (wr[win_id_c]) begin
            mem_waddr_d = win_addr_c;
            mem_din_d   = win_wdata_c;
            state_d     = ST_WR_SETUP;
          end else begin
            state_d     = ST_RD;
          end
        end
      end
      ST_RD: begin
        rdata_d = mem_dout;
        done_d  = id2oh(cmd_q.id);
        state_d = ST_IDLE;
      end
      ST_WR_SETUP: begin
        mem_we_d = 1'b1;
        state_d  = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        done_d  = id2oh(cmd_q.id);
        state_d = ST_WR_DONE;
      end
      ST_WR_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      last_q      <= 1'b1;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_waddr_q <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt_q  <= '0;
      lock_act_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_waddr_q <= mem_waddr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
      lock_act_q  <= lock_act_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-timeline model.
module tb_dmem_arbiter;

  localparam int LOCK_MAX = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, wr;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [1:0] lock;
  logic [1:0] gnt, done;
  logic [7:0] rdata, mem_raddr, mem_waddr, mem_din, mem_dout;
  logic       mem_we;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wr        (wr),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
`ifdef DMEM_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_we    (mem_we),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // Data memory attached to the DUT: combinational read, write on mem_we rising edge
  logic [7:0] tb_mem [256] = '{default: 8'h00};
  assign mem_dout = tb_mem[mem_raddr];
  always @(posedge mem_we) tb_mem[mem_waddr] <= mem_din;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  // Requester drivers
  logic       pend  [2];
  logic       pwr   [2];
  logic [7:0] paddr [2];
  logic [7:0] pdata [2];
  int         rate  [2];
  int         wmode;

  // Reference model: one transaction in flight, counted in cycles since its grant
  int         phase;
  logic       m_id, m_wr, m_last, m_lock;
  int         m_run;
  logic [7:0] m_addr, m_data;
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [7:0] exp_rdata, exp_waddr, exp_din;
  logic       cyc_we;
  logic [1:0] gcap [16];
  int         gcap_n;

  task automatic model_reset();
    phase = 0; m_last = 1'b1; m_lock = 1'b0; m_run = 0;
    m_id = 1'b0; m_wr = 1'b0; m_addr = 8'h00; m_data = 8'h00;
    exp_rdata = 8'h00; exp_waddr = 8'h00; exp_din = 8'h00;
    gcap_n = 0;
    for (int i = 0; i < 2; i++) pend[i] = 1'b0;
    req = 2'b00;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_raddr", mem_raddr, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_din", mem_din, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: compare outputs, update requesters, predict the coming edge
  task automatic step();
    logic [1:0] eg, ed;
    logic       ew, elig, w;
    @(negedge clk);
    eg = (phase == 1) ? oh(m_id) : 2'b00;
    ed = ((phase == 2 && !m_wr) || (phase == 3 && m_wr)) ? oh(m_id) : 2'b00;
    ew = (phase == 2 && m_wr);
    if (phase == 2 && !m_wr) exp_rdata = ref_mem[m_addr];
    if (ew) ref_mem[m_addr] = m_data;
    chk("gnt", gnt, eg);
    chk("done", done, ed);
    chk("mem_we", mem_we, ew);
    chk("rdata", rdata, exp_rdata);
    chk("mem_waddr", mem_waddr, exp_waddr);
    chk("mem_din", mem_din, exp_din);
    if (phase == 1 && !m_wr) chk("mem_raddr", mem_raddr, m_addr);
    cyc_we = ew;
    if (gnt != 2'b00 && gcap_n < 16) begin
      gcap[gcap_n] = gnt;
      gcap_n++;
    end
    for (int i = 0; i < 2; i++) begin
      if (eg[i]) pend[i] = 1'b0;
      if (!pend[i] && rate[i] > int'($urandom_range(0, 99))) begin
        pend[i]  = 1'b1;
        pwr[i]   = (wmode == 2) ? 1'($urandom) : 1'(wmode);
        paddr[i] = 8'($urandom);
        pdata[i] = 8'($urandom);
      end
    end
    req    = {pend[1], pend[0]};
    wr     = {pwr[1], pwr[0]};
    addr0  = paddr[0]; addr1  = paddr[1];
    wdata0 = pdata[0]; wdata1 = pdata[1];
    elig = (phase == 0) || (phase == 2 && !m_wr) || (phase == 4 && m_wr);
    if (elig && req != 2'b00) begin
      if (req == 2'b01) w = 1'b0;
      else if (req == 2'b10) w = 1'b1;
      else w = ~m_last;
`ifdef DMEM_ARB_LOCK_EN
      if (m_lock && m_run < LOCK_MAX && req[m_last]) w = m_last;
      m_run  = (w == m_last) ? m_run + 1 : 1;
      m_lock = lock[w];
`endif
      m_last = w; m_id = w; m_wr = wr[w];
      m_addr = w ? addr1 : addr0;
      m_data = w ? wdata1 : wdata0;
      if (m_wr) begin
        exp_waddr = m_addr;
        exp_din   = m_data;
      end
      phase = 1;
    end else if (elig) begin
      phase = 0;
    end else begin
      phase++;
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    pend[i] = 1'b1; pwr[i] = w; paddr[i] = a; pdata[i] = d;
  endtask

  initial begin
    rst_n = 1'b1; req = 2'b00; wr = 2'b00; lock = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rate[0] = 0; rate[1] = 0; wmode = 0; cyc_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pwr[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
    end
    model_reset();
    #3;
    apply_reset();

    // Single write by requester 0
    set_req(0, 1'b1, 8'h1F, 8'h07);
    repeat (6) step();
    chk("w1_mem", tb_mem[8'h1F], 8'h07);

    // Load 0xFF then single read of it by requester 1
    set_req(0, 1'b1, 8'hFF, 8'h0F);
    repeat (6) step();
    set_req(1, 1'b0, 8'hFF, 8'h00);
    repeat (4) step();
    chk("r1_rdata", rdata, 8'h0F);

    // Contention from reset, reads only
    apply_reset();
    rate[0] = 100; rate[1] = 100; wmode = 0;
    repeat (12) step();
    for (int i = 0; i < 4; i++) chk("rr_order", gcap[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    rate[0] = 0; rate[1] = 0;
    repeat (8) step();

    // Back-to-back writes by requester 0
    set_req(0, 1'b1, 8'h10, 8'hA5);
    for (int n = 0; n < 20 && pend[0]; n++) step();
    chk("b2b_gnt_wait", pend[0], 0);
    set_req(0, 1'b1, 8'h11, 8'h5A);
    repeat (8) step();
    chk("b2b_mem0", tb_mem[8'h10], 8'hA5);
    chk("b2b_mem1", tb_mem[8'h11], 8'h5A);

    // Reset while the write strobe is high
    set_req(0, 1'b1, 8'h20, 8'hC3);
    cyc_we = 1'b0;
    for (int n = 0; n < 10 && !cyc_we; n++) step();
    chk("pulse_wait", cyc_we, 1);
    apply_reset();
    set_req(0, 1'b0, 8'h10, 8'h00);
    set_req(1, 1'b0, 8'h11, 8'h00);
    repeat (6) step();
    chk("rst_tie_first", gcap[0], 2'b01);

`ifdef DMEM_ARB_LOCK_EN
    // Locked requester 0 keeps the memory for LOCK_MAX grants
    apply_reset();
    lock = 2'b01;
    rate[0] = 100; rate[1] = 100; wmode = 0;
    repeat (22) step();
    for (int i = 0; i < LOCK_MAX; i++) chk("lock_run", gcap[i], 2'b01);
    chk("lock_release", gcap[LOCK_MAX], 2'b10);
    rate[0] = 0; rate[1] = 0;
    repeat (8) step();
    lock = 2'b00;
`endif

    // Random mixed traffic
    rate[0] = 40; rate[1] = 40; wmode = 2;
    repeat (1500) step();
    rate[0] = 0; rate[1] = 0;
    repeat (12) step();
    for (int a = 0; a < 256; a++) chk("mem_final", tb_mem[a], ref_mem[a]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 8, address width.
REQ-002 Parameter DW, default 8, data width.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req  input  2  per-requester transaction request (bit0 = CPU, bit1 = loader/debug).
REQ-006 Port wr  input  2  per-requester command: 1 = write, 0 = read.
REQ-007 Port addr0, addr1  input  AW each  per-requester address.
REQ-008 Port wdata0, wdata1  input  DW each  per-requester write data.
REQ-009 Port gnt  output  2  one-hot grant, one cycle per transaction.
REQ-010 Port done  output  2  one-hot completion pulse, one cycle.
REQ-011 Port rdata  output  DW  read data, valid while done is high for a read.
REQ-012 Port mem_raddr, mem_waddr  output  AW  data-memory read/write address.
REQ-013 Port mem_we  output  1  data-memory write strobe (memory writes on its rising edge).
REQ-014 Port mem_din  output  DW  data-memory write data.
REQ-015 Port mem_dout  input  DW  data-memory combinational read data.

Function
REQ-016 FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_DONE.
REQ-017 IDLE, req==0: stay IDLE; all strobes low.
REQ-018 IDLE, req!=0: at the edge, pick winner, latch its wr/addr/wdata, register gnt[winner]=1 for the next cycle, go RD (wr=0) or WR_SETUP (wr=1).
REQ-019 Arbitration: one requester -> it wins; both -> winner is the requester NOT granted last (round-robin); pointer updates on every grant.
REQ-020 RD (1 cycle): mem_raddr = latched addr; at exit edge rdata <= mem_dout, done[winner]=1 next cycle, go IDLE.
REQ-021 WR_SETUP (1 cycle): mem_waddr/mem_din = latched values, mem_we=0; go WR_PULSE.
REQ-022 WR_PULSE (1 cycle): mem_we=1, address/data unchanged; go WR_DONE.
REQ-023 WR_DONE (1 cycle): mem_we=0, done[winner]=1; go IDLE.
REQ-024 Latency: read gnt->done 1 cycle; write gnt->done 2 cycles; mem_we is never high in two consecutive cycles, guaranteeing an edge per write.
REQ-025 IDLE re-arbitrates in the same cycle done is high (back-to-back reads: one grant every 2 cycles).
REQ-026 Requester holds req/wr/addr/wdata until it sees gnt; req is ignored outside IDLE.
REQ-027 mem_waddr, mem_din hold their last value outside write states; rdata holds until next read completes.
REQ-028 gnt and done are never high for both requesters in the same cycle.

Reset
REQ-029 rst_n low: immediately gnt=0, done=0, rdata=0, mem_we=0, mem_raddr=0, mem_waddr=0, mem_din=0, state IDLE, round-robin pointer = requester 1 (requester 0 wins first tie).
REQ-030 Reset during any state aborts the transaction without done; reset during WR_PULSE drops mem_we asynchronously.

Configuration
REQ-031 Macro DMEM_ARB_LOCK_EN: when defined, adds input lock (2 bits) and parameter LOCK_MAX (default 8).
REQ-032 With it: if the last winner had lock high at its grant and requests again, it wins regardless of pointer, up to LOCK_MAX consecutive grants, then the other requester (if requesting) wins next; counter clears on any grant to the other side.
REQ-033 Without it: no lock port, no counter, pure round-robin per REQ-019.

Structure
REQ-034 Package dmem_arb_pkg holds the FSM state enum, requester-count constant (2) and the latched-command struct (wr, addr, wdata, id).
REQ-035 Sub-module rr_pick2: combinational 2-way round-robin picker (req, last, optional lock override) -> one-hot winner.

Verification
REQ-036 Single write: req=01, wr=01, addr0=0x1F, wdata0=0x07 -> gnt=01 next cycle, mem_we high exactly 1 cycle with mem_waddr=0x1F/mem_din=0x07, done=01 two cycles after gnt.
REQ-037 Single read: memory[0xFF]=0x0F, req=10, addr1=0xFF -> gnt=10, done=10 next cycle with rdata=0x0F.
REQ-038 Contention: req=11 held, all reads -> grants alternate 01,10,01,10 from reset, one grant per 2 cycles.
REQ-039 Back-to-back writes by requester 0 to 0x10,0x11 -> mem_we low at least 1 cycle between the two pulses; both locations updated.
REQ-040 rst_n low during WR_PULSE -> mem_we and all outputs 0 in the same cycle, no done, first grant after release goes to requester 0 on tie.
REQ-041 DMEM_ARB_LOCK_EN, LOCK_MAX=8, req=11, lock=01 -> requester 0 granted 8 times consecutively, then requester 1 granted.
